lr35902_irq_ctrl: RTL and testbench

Interrupt controller for the LR35902 core. It collects the five peripheral request lines: vblank, LCD STAT, timer, serial (the serial-link peripheral's `irq` pulse) and joypad. It holds the IF (0xFF0F) and IE (0xFFFF) registers on the peripheral bus. It presents the highest-priority pending, enabled request to the CPU as a vector, and clears that request on acknowledge.

---
 rtl/lr35902_irq_pkg.sv | 22 ++
 rtl/lr35902_irq_prio.sv | 27 ++
 rtl/lr35902_irq_ctrl.sv | 110 +++++++++++
 tb/tb_lr35902_irq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lr35902_irq_pkg.sv
// Shared constants for the LR35902 interrupt controller: source indices,
// vector layout and the IF read-back filler bits.
package lr35902_irq_pkg;

    localparam int NUM_IRQ = 5;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam logic [7:0] IRQ_VEC_BASE   = 8'h40;
    localparam int         IRQ_VEC_STRIDE = 8;

    localparam logic [2:0] IF_UNUSED = 3'b111;

    function automatic logic [7:0] irq_vector(input int n);
        return IRQ_VEC_BASE + 8'(n * IRQ_VEC_STRIDE);
    endfunction

endpackage

// File: rtl/lr35902_irq_prio.sv
// Fixed-priority encoder: bit 0 wins. Produces the service vector and the
// one-hot of the chosen source so the same selection can drive the ack clear.
module lr35902_irq_prio
    import lr35902_irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] pending_i,
    output logic               valid_o,
    output logic [7:0]         vec_o,
    output logic [NUM_IRQ-1:0] onehot_o
);

    always_comb begin
        valid_o  = 1'b0;
        vec_o    = 8'h00;
        onehot_o = '0;
        // Walk from lowest priority upward so the last hit is the winner.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                valid_o     = 1'b1;
                vec_o       = irq_vector(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lr35902_irq_ctrl.sv
// LR35902 interrupt controller: IF/IE registers, edge-detected request capture
// and vectored CPU request/ack. Define LR35902_IRQ_SYNC_EN to double-flop irq_in.
module lr35902_irq_ctrl
    import lr35902_irq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    output logic [7:0]         dout,
    input  logic [7:0]         din,
    input  logic               adr,
    input  logic               write,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_ack,
    output logic               int_req,
    output logic [7:0]         int_vec
);

    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic               pwrite_q;
    logic               pack_q;
    logic [7:0]         dout_q, dout_d;
    logic               int_req_q;
    logic [7:0]         int_vec_q;
    logic [NUM_IRQ-1:0] sel_onehot_q;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] set_mask;
    logic [NUM_IRQ-1:0] ack_mask;
    logic               wr_commit;
    logic               ack_edge;
    logic               prio_valid;
    logic [7:0]         prio_vec;
    logic [NUM_IRQ-1:0] prio_onehot;

`ifdef LR35902_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign set_mask  = irq_s & ~irq_prev_q;
    assign wr_commit = pwrite_q & ~write;
    assign ack_edge  = int_ack & ~pack_q;
    // The clear targets the source named by the vector the CPU is looking at.
    assign ack_mask  = ack_edge ? sel_onehot_q : '0;

    lr35902_irq_prio u_prio (
        .pending_i (if_q & ie_q[NUM_IRQ-1:0]),
        .valid_o   (prio_valid),
        .vec_o     (prio_vec),
        .onehot_o  (prio_onehot)
    );

    always_comb begin
        if_d = if_q;
        ie_d = ie_q;
        if (wr_commit && adr == 1'b0) begin
            if_d = din[NUM_IRQ-1:0];
        end
        if (wr_commit && adr == 1'b1) begin
            ie_d = din;
        end
        // New edges are OR-ed last so neither ack nor a bus write can drop them.
        if_d = (if_d & ~ack_mask) | set_mask;
        dout_d = adr ? ie_q : {IF_UNUSED, if_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_q         <= '0;
            ie_q         <= 8'h00;
            irq_prev_q   <= '0;
            pwrite_q     <= 1'b0;
            pack_q       <= 1'b0;
            dout_q       <= 8'h00;
            int_req_q    <= 1'b0;
            int_vec_q    <= 8'h00;
            sel_onehot_q <= '0;
        end else begin
            if_q         <= if_d;
            ie_q         <= ie_d;
            irq_prev_q   <= irq_s;
            pwrite_q     <= write;
            pack_q       <= int_ack;
            dout_q       <= dout_d;
            int_req_q    <= prio_valid;
            int_vec_q    <= prio_vec;
            sel_onehot_q <= prio_onehot;
        end
    end

    assign dout    = dout_q;
    assign int_req = int_req_q;
    assign int_vec = int_vec_q;

endmodule

// File: tb/tb_lr35902_irq_ctrl.sv
// Self-checking bench for lr35902_irq_ctrl (default build, no input synchronizer).
module tb_lr35902_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] dout;
    logic [7:0] din;
    logic       adr;
    logic       write;
    logic [4:0] irq_in;
    logic       int_ack;
    logic       int_req;
    logic [7:0] int_vec;

    int n_total;
    int n_bad;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    lr35902_irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .dout    (dout),
        .din     (din),
        .adr     (adr),
        .write   (write),
        .irq_in  (irq_in),
        .int_ack (int_ack),
        .int_req (int_req),
        .int_vec (int_vec)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%03h exp=0x%03h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic req, input logic [7:0] vec);
        check_val(tag, {int_req, int_vec}, {req, vec});
    endtask

    // Read a register: expectation queued when the select is driven,
    // compared once the registered read data has been produced.
    task automatic rd(input logic a, input string tag, input logic [7:0] exp);
        logic [8:0] e;
        string      t;
        adr = a;
        exp_q.push_back({1'b0, exp});
        tag_q.push_back(tag);
        tick();
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 9'h1ff, 9'h000);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, {1'b0, dout}, e);
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        adr   = a;
        din   = d;
        write = 1'b1;
        tick();
        write = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [4:0] m);
        irq_in = m;
        tick();
        irq_in = 5'b0;
        check_out("pulse_lat1", 1'b0, 8'h00);
        tick();
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
    endtask

    initial begin
        int         n;
        logic [4:0] m;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        din     = 8'h00;
        adr     = 1'b0;
        write   = 1'b0;
        irq_in  = 5'b0;
        int_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        check_out("rst_out", 1'b0, 8'h00);
        rd(1'b0, "rst_if", 8'he0);
        rd(1'b1, "rst_ie", 8'h00);

        // single timer request
        wr(1'b1, 8'h1f);
        rd(1'b1, "ie_1f", 8'h1f);
        pulse(5'b00100);
        check_out("timer_vec", 1'b1, 8'h50);
        rd(1'b0, "timer_if", 8'he4);
        ack();
        check_out("timer_ack", 1'b0, 8'h00);

        // two simultaneous requests, served in priority order
        pulse(5'b10010);
        check_out("stat_vec", 1'b1, 8'h48);
        ack();
        check_out("joy_vec", 1'b1, 8'h60);
        rd(1'b0, "if_f0", 8'hf0);
        ack();
        check_out("all_clr", 1'b0, 8'h00);
        rd(1'b0, "if_e0", 8'he0);

        // disabled source does not request; edge beats a clearing IF write
        wr(1'b0, 8'h08);
        wr(1'b1, 8'h00);
        tick();
        check_out("ie_off", 1'b0, 8'h00);
        rd(1'b0, "if_e8", 8'he8);
        adr   = 1'b0;
        din   = 8'h00;
        write = 1'b1;
        tick();
        write  = 1'b0;
        irq_in = 5'b01000;
        tick();
        irq_in = 5'b0;
        rd(1'b0, "edge_vs_wr", 8'he8);

        // source held high across reset release; held ack clears one bit
        irq_in = 5'b00001;
        reset  = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        rd(1'b0, "held_src", 8'he1);
        wr(1'b1, 8'h05);
        wr(1'b0, 8'h05);
        tick();
        check_out("vblank_vec", 1'b1, 8'h40);
        int_ack = 1'b1;
        repeat (4) tick();
        int_ack = 1'b0;
        tick();
        check_out("held_ack", 1'b1, 8'h50);
        rd(1'b0, "held_ack_if", 8'he4);

        // reset in the middle of a bus write
        irq_in = 5'b0;
        tick();
        adr   = 1'b1;
        din   = 8'h1f;
        write = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_out("midwr_out", 1'b0, 8'h00);
        check_val("midwr_dout", {1'b0, dout}, 9'h000);
        write = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        rd(1'b1, "midwr_ie", 8'h00);
        rd(1'b0, "midwr_if", 8'he0);

        // randomized single-source requests
        wr(1'b1, 8'h1f);
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 4);
            m = 5'(1 << n);
            pulse(m);
            check_out("rand_vec", 1'b1, 8'h40 + 8'(n * 8));
            ack();
            check_out("rand_ack", 1'b0, 8'h00);
        end

        if (exp_q.size() != 0) begin
            check_val("sb_left", 9'(exp_q.size()), 9'h000);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
